// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: major opcodes and the immediate-format selector.
package riscv_pkg;

   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from instr[31].
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   input  imm_type_e   imm_type,
   output logic [31:0] imm
);

   always_comb begin
      unique case (imm_type)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'b0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-index slicing, writeback bypass, immediate generation,
// load-use interlock and a single-entry ID/EX register with valid/ready on both sides.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   input  logic [31:0]     r1,
   input  logic [31:0]     r2,
   input  logic            wb_wen,
   input  logic [4:0]      wb_rd,
   input  logic [31:0]     wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [31:0]     ex_op1,
   output logic [31:0]     ex_op2,
   output logic [31:0]     ex_imm,
   output logic [4:0]      ex_rd,
   output logic            ex_rd_wen,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_is_load,
   output logic            ex_illegal
);

   logic [6:0]  opcode;
   logic [4:0]  rd;
   imm_type_e   imm_type;
   logic        legal;
   logic        writes_rd;
   logic [31:0] imm;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        hazard;
   logic        accept;

   assign rs1    = if_instr[19:15];
   assign rs2    = if_instr[24:20];
   assign rd     = if_instr[11:7];
   assign opcode = if_instr[6:0];

   // x0 always reads zero (the register file does not enforce it), then same-cycle writeback wins.
   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf_data,
                                           input logic wen, input logic [4:0] wrd,
                                           input logic [31:0] wdata);
      if (idx == 5'd0)
         return 32'b0;
      else if (wen && wrd == idx)
         return wdata;
      else
         return rf_data;
   endfunction

   assign op1 = operand(rs1, r1, wb_wen, wb_rd, wb_data);
   assign op2 = operand(rs2, r2, wb_wen, wb_rd, wb_data);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      imm_type  = IMM_NONE;
      legal     = 1'b1;
      writes_rd = 1'b0;
      case (opcode)
         LOAD, OP_IMM, JALR: begin
            imm_type  = IMM_I;
            writes_rd = 1'b1;
         end
         STORE:      imm_type = IMM_S;
         BRANCH:     imm_type = IMM_B;
         LUI, AUIPC: begin
            imm_type  = IMM_U;
            writes_rd = 1'b1;
         end
         JAL: begin
            imm_type  = IMM_J;
            writes_rd = 1'b1;
         end
         OP:               writes_rd = 1'b1;
         SYSTEM, MISC_MEM: writes_rd = 1'b0;
         default:          legal     = 1'b0;
      endcase
   end

   imm_gen u_imm_gen (
      .instr    (if_instr),
      .imm_type (imm_type),
      .imm      (imm)
   );

   // A load in EX whose result is needed now must let one bubble through before we accept.
   assign hazard   = ex_valid && ex_is_load && (ex_rd != 5'd0) && (ex_rd == rs1 || ex_rd == rs2);
   assign if_ready = !rst && !flush && !hazard && (!ex_valid || ex_ready);
   assign accept   = if_valid && if_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_op1      <= '0;
         ex_op2      <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_rd_wen   <= 1'b0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_is_load  <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         // NOTE: flush only drops ex_valid; the payload is meaningless once unqualified.
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_op1      <= op1;
         ex_op2      <= op2;
         ex_imm      <= imm;
         ex_rd       <= rd;
         ex_rd_wen   <= legal && writes_rd && (rd != 5'd0);
         ex_opcode   <= opcode;
         ex_funct3   <= if_instr[14:12];
         ex_funct7b5 <= if_instr[30];
         ex_is_load  <= (opcode == LOAD);
         ex_illegal  <= !legal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode stage that sits between the fetch stage and the execute stage, directly around `RegisterFile`. It slices the fetched instruction into source and destination register indices and drives them to `RegisterFile`. It merges the returned operands with a same-cycle writeback bypass, generates the immediate, and captures everything into a single-entry ID/EX pipeline register with valid/ready handshakes on both sides. It also enforces the one-bubble load-use interlock and honours pipeline flush.

## Interface
- `XLEN`, default 32: datapath and PC width.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `if_valid` input 1: fetch presents an instruction.
- `if_ready` output 1: the stage accepts the instruction this cycle.
- `if_instr` input 32: instruction word.
- `if_pc` input XLEN: PC of `if_instr`.
- `rs1` output 5: equals `if_instr[19:15]`; combinational, to `RegisterFile`.
- `rs2` output 5: equals `if_instr[24:20]`; combinational, to `RegisterFile`.
- `r1` input 32: `RegisterFile` read data for `rs1`.
- `r2` input 32: `RegisterFile` read data for `rs2`.
- `wb_wen` input 1: writeback writes `RegisterFile` at the next edge.
- `wb_rd` input 5: writeback destination register.
- `wb_data` input 32: writeback data.
- `flush` input 1: kill the held entry and refuse new input this cycle.
- `ex_valid` output 1: the ID/EX register holds a valid instruction.
- `ex_ready` input 1: execute consumes the entry this cycle.
- `ex_pc` output XLEN: registered PC.
- `ex_op1` output 32: registered rs1 value.
- `ex_op2` output 32: registered rs2 value.
- `ex_imm` output 32: registered sign-extended immediate.
- `ex_rd` output 5: registered destination register.
- `ex_rd_wen` output 1: the instruction writes `rd` (forced 0 when rd = x0).
- `ex_opcode` output 7: registered opcode.
- `ex_funct3` output 3: registered funct3.
- `ex_funct7b5` output 1: registered `instr[30]`.
- `ex_is_load` output 1: registered flag, set when opcode is LOAD.
- `ex_illegal` output 1: registered flag, set when the opcode is not an RV32I major opcode.

## Operation
- Accept condition: transfer in when `if_valid && if_ready`.
- `if_ready = !flush && !hazard && (!ex_valid || ex_ready)`.
- Load-use hazard definition: `hazard = ex_valid && ex_is_load && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2)`.
- Load-use hazard behaviour: when `ex_ready` is high during a hazard, the register loads a bubble (`ex_valid` becomes 0). The dependent instruction is accepted on the following cycle, so exactly one bubble is inserted.
- Operand select, in priority order:
  1. Source index 0 reads 0. `RegisterFile` does not zero x0, so this stage enforces it.
  2. If `wb_wen && wb_rd == rsN && rsN != 0`, use `wb_data`.
  3. Otherwise use `r1`/`r2`.
- Immediates:
  - I type: LOAD, OP-IMM, JALR.
  - S type: STORE.
  - B type: BRANCH.
  - U type: LUI, AUIPC.
  - J type: JAL.
  - R type and illegal: 0.
  - All immediates are sign-extended from `instr[31]`.
- `ex_rd_wen` is 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP with rd ≠ 0; it is 0 otherwise.
- Illegal instruction: sets `ex_illegal = 1`, `ex_rd_wen = 0`, and still flows with `ex_valid = 1`.
- Register update, in priority order:
  1. `rst`: clear.
  2. `flush`: set `ex_valid` to 0.
  3. Accept: load the new payload and set `ex_valid` to 1.
  4. `ex_ready` without accept: set `ex_valid` to 0.
  5. Otherwise: hold.
- Payload registers only change on accept; they hold their value during stall.

## Timing
- Reset value: `ex_valid` and every `ex_*` output read 0 after the reset edge. During `rst`, `if_ready` is 0.
- Latency: one cycle. An instruction accepted at edge N appears on `ex_*` after edge N.
- Throughput: one instruction per cycle while `ex_ready` stays high.
- Backpressure: `ex_*` outputs are stable while `ex_valid && !ex_ready`.
- Flush together with `if_valid`: the incoming instruction is dropped and not captured. Flush together with `ex_ready`: the held entry counts as consumed.
- Reset mid-stall: the held entry is discarded; no instruction replays.
- `rs1`/`rs2` are driven combinationally from `if_instr` every cycle, independent of `if_valid`.

## Structure
- Shared package `riscv_pkg`: opcode localparams (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, SYSTEM, MISC_MEM) and the `imm_type_e` enum (I, S, B, U, J, NONE).
- Sub-module `imm_gen`: combinational; takes the instruction word and `imm_type_e`, produces the 32-bit immediate.
- All other logic, including the hazard, bypass and ID/EX register, stays in `decode_stage`.

## Test plan
- Basic I-type: after reset, present `addi x5,x1,-1` (0xFFF08293) with `r1 = 7`. Next cycle: `ex_valid = 1`, `ex_op1 = 7`, `ex_imm = 0xFFFFFFFF`, `ex_rd = 5`, `ex_rd_wen = 1`.
- Writeback bypass and x0:
  - `add x3,x2,x0` with `wb_wen = 1`, `wb_rd = 2`, `wb_data = 0xA5A5A5A5`, `r1 = 0`, `r2 = 0x1234`. Required: `ex_op1 = 0xA5A5A5A5`, `ex_op2 = 0`.
  - Same instruction with `wb_rd = 0`. Required: no bypass.
- Load-use interlock: `lw x6,0(x1)` followed by `add x7,x6,x6`, with `ex_ready = 1`. Required: `if_ready` low for exactly one cycle, one bubble on `ex_valid`, then `add` with `ex_rd = 7`.
- Backpressure: hold `ex_ready = 0` for 3 cycles with `if_valid = 1`. Required: `if_ready = 0` and `ex_*` constant; after release, the next instruction is accepted with none lost or duplicated.
- Flush: flush while holding a valid entry and `if_valid = 1`. Required: `ex_valid = 0` next cycle and the incoming PC never appears on `ex_pc`.
- Immediate and illegal decode:
  - `jal x1,-4` (0xFFDFF0EF): `ex_imm = 0xFFFFFFFC`.
  - `beq` with offset +8: `ex_imm = 8`, `ex_rd_wen = 0`.
  - Opcode 0x7F: `ex_illegal = 1`, `ex_rd_wen = 0`.
